// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - SHA-256 constants, types, FSM states and round functions
package sha_pkg;

  localparam int ROUNDS = 64;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Packed so that field a lands in the top word, matching the H_in/hash packing
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL
  } fsm_t;

  localparam word_t K [0:ROUNDS-1] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha_sched_window.sv
// rtl/sha_sched_window.sv - 16-word message schedule window with on-the-fly sigma extension
module sha_sched_window
  import sha_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block,
  output word_t        w_t
);

  word_t win [0:15];
  word_t tail;

  // win[k] holds W(t+k), so the appended word is W(t+16)
  assign tail = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
  assign w_t  = win[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block[511-32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= tail;
    end
  end

endmodule

// File: rtl/sha_compress.sv
// rtl/sha_compress.sv - SHA-256 one-round-per-clock compression; SHA_OUT_BSWAP_EN byte-reverses hash words
module sha_compress
  import sha_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [511:0] M,
  input  logic [255:0] H_in,
  output logic         ready,
  output logic [255:0] hash,
  output logic         en_next
);

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  fsm_t         state;
  logic [5:0]   t;
  state_t       v;
  state_t       v_next;
  state_t       h_reg;
  state_t       sum;
  logic [255:0] hash_q;
  word_t        w_t;
  word_t        t1;
  word_t        t2;
  logic         accept;

  assign accept = (state == S_IDLE) && en;

  sha_sched_window u_window (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state == S_ROUND),
    .block (M),
    .w_t   (w_t)
  );

  always_comb begin
    t1     = v.h + big_sigma1(v.e) + ch(v.e, v.f, v.g) + K[t] + w_t;
    t2     = big_sigma0(v.a) + maj(v.a, v.b, v.c);
    v_next = '{a: t1 + t2, b: v.a, c: v.b, d: v.c, e: v.d + t1, f: v.e, g: v.f, h: v.g};
  end

  assign sum = '{a: h_reg.a + v.a, b: h_reg.b + v.b, c: h_reg.c + v.c, d: h_reg.d + v.d,
                 e: h_reg.e + v.e, f: h_reg.f + v.f, g: h_reg.g + v.g, h: h_reg.h + v.h};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      t       <= '0;
      ready   <= 1'b1;
      en_next <= 1'b0;
      hash_q  <= '0;
      h_reg   <= '0;
      v       <= '0;
    end else begin
      en_next <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            h_reg <= state_t'(H_in);
            v     <= state_t'(H_in);
            t     <= '0;
            ready <= 1'b0;
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          v <= v_next;
          t <= t + 6'd1;
          if (t == LAST_ROUND) state <= S_FINAL;
        end
        S_FINAL: begin
          hash_q  <= sum;
          en_next <= 1'b1;
          ready   <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SHA_OUT_BSWAP_EN
  for (genvar w = 0; w < 8; w++) begin : g_word
    for (genvar b = 0; b < 4; b++) begin : g_byte
      assign hash[32*w+8*b +: 8] = hash_q[32*w+8*(3-b) +: 8];
    end
  end
`else
  assign hash = hash_q;
`endif

endmodule

// File: tb/tb_sha_compress.sv
// tb/tb_sha_compress.sv - scoreboard bench for sha_compress
module tb_sha_compress;
  import sha_pkg::*;

  localparam logic [511:0] ABC_M   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_M = {32'h80000000, 480'h0};
  localparam logic [255:0] ABC_D   =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  typedef struct {
    logic [255:0] d;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [511:0] M;
  logic [255:0] H_in;
  logic         ready;
  logic [255:0] hash;
  logic         en_next;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_next   = 0;
  logic prev_next = 1'b0;
  exp_t sb[$];
  logic [255:0] iv_val;

  sha_compress dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .M       (M),
    .H_in    (H_in),
    .ready   (ready),
    .hash    (hash),
    .en_next (en_next)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] present(input logic [255:0] d);
    logic [255:0] r;
    r = d;
`ifdef SHA_OUT_BSWAP_EN
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 4; b++)
        r[32*w+8*b +: 8] = d[32*w+8*(3-b) +: 8];
`endif
    return r;
  endfunction

  // Called at a negedge; a block counts as accepted only if ready is high now
  task automatic send(input logic [511:0] m, input logic [255:0] exp);
    M    = m;
    H_in = iv_val;
    en   = 1'b1;
    if (ready) sb.push_back('{d: present(exp), acc: cyc});
    @(negedge clk);
    en = 1'b0;
    M  = '1;
    H_in = '1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check(tag, 256'(sb.size()), 256'd0);
  endtask

  always @(negedge clk) begin
    if (reset && en_next) begin
      n_next++;
      if (prev_next) check("en_next_double", 256'd1, 256'd0);
      if (sb.size() == 0) begin
        check("spurious_en_next", 256'd1, 256'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("digest", hash, e.d);
        check("latency", 256'(cyc - e.acc), 256'd66);
      end
    end
    prev_next = en_next;
  end

  initial begin
    for (int i = 0; i < 8; i++) iv_val[255-32*i -: 32] = IV[i];
    reset = 1'b0;
    en    = 1'b0;
    M     = '0;
    H_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 256'(ready), 256'd1);
    check("reset_en_next", 256'(en_next), 256'd0);
    check("reset_hash", hash, 256'd0);
    reset = 1'b1;
    @(negedge clk);

    send(ABC_M, ABC_D);
    @(negedge clk);
    check("busy_ready", 256'(ready), 256'd0);
    drain("abc_drain");

    send(EMPTY_M, EMPTY_D);
    drain("empty_drain");
    check("hash_hold", hash, present(EMPTY_D));

    send(ABC_M, ABC_D);
    for (int i = 0; i < 100 && !en_next; i++) @(negedge clk);
    check("b2b_first_seen", 256'(en_next), 256'd1);
    check("b2b_ready_with_next", 256'(ready), 256'd1);
    send(EMPTY_M, EMPTY_D);
    drain("b2b_drain");

    send(ABC_M, ABC_D);
    repeat (9) @(negedge clk);
    send(EMPTY_M, EMPTY_D);
    drain("ignore_drain");

    send(ABC_M, ABC_D);
    repeat (29) @(negedge clk);
    reset = 1'b0;
    sb.delete(sb.size() - 1);
    repeat (3) @(negedge clk);
    check("abort_ready", 256'(ready), 256'd1);
    check("abort_hash", hash, 256'd0);
    check("abort_en_next", 256'(en_next), 256'd0);
    reset = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_hash_after", hash, 256'd0);

    send(ABC_M, ABC_D);
    drain("fresh_drain");

    check("en_next_total", 256'(n_next), 256'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
